// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Brief  : Shared register map, CTRL/STATUS bit positions and FSM state type
//          for the FIFO-to-RAM DMA controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dma_pkg;

  localparam logic [31:0] DMA_OFF_DST    = 32'h0000_0000;
  localparam logic [31:0] DMA_OFF_LEN    = 32'h0000_0004;
  localparam logic [31:0] DMA_OFF_CTRL   = 32'h0000_0008;
  localparam logic [31:0] DMA_OFF_STATUS = 32'h0000_000C;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_ABORT_BIT   = 2;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_ABORTED_BIT = 2;

  typedef enum logic [0:0] {
    DMA_IDLE = 1'b0,
    DMA_XFER = 1'b1
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_dma_ctrl.sv
// ============================================================================
// Module : fifo_dma_ctrl
// Brief  : MMIO-programmed DMA that drains a FWFT FIFO into RAM port B,
//          yielding the port to the CPU whenever it requests it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_dma_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES = 2**16,
  parameter logic [31:0] MMIO_BASE      = 32'h4000_0030
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mmio_wr_en,
  input  logic [31:0] i_mmio_wr_addr,
  input  logic [31:0] i_mmio_wr_data,
  input  logic [31:0] i_mmio_rd_addr,
  output logic [31:0] o_mmio_rd_data,
  input  logic        i_cpu_mem_req,
  output logic        o_dma_mem_sel,
  output logic [31:0] o_dma_mem_addr,
  output logic [31:0] o_dma_mem_wr_data,
  output logic [3:0]  o_dma_mem_we,
  input  logic [31:0] i_fifo_rd_data,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rd_en,
  output logic        o_irq
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_SIZE_BYTES - 1);

  dma_state_e  state_q, state_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;
  logic        irq_q, irq_d;

  logic        w_busy;
  logic        w_wr_dst, w_wr_len, w_wr_ctrl, w_wr_status;
  logic        w_start, w_abort, w_beat;
  logic [31:0] w_rd_data;

  assign w_busy      = (state_q == DMA_XFER);
  assign w_wr_dst    = i_mmio_wr_en && (i_mmio_wr_addr == MMIO_BASE + DMA_OFF_DST);
  assign w_wr_len    = i_mmio_wr_en && (i_mmio_wr_addr == MMIO_BASE + DMA_OFF_LEN);
  assign w_wr_ctrl   = i_mmio_wr_en && (i_mmio_wr_addr == MMIO_BASE + DMA_OFF_CTRL);
  assign w_wr_status = i_mmio_wr_en && (i_mmio_wr_addr == MMIO_BASE + DMA_OFF_STATUS);
  assign w_start     = w_wr_ctrl && i_mmio_wr_data[CTRL_START_BIT];
  assign w_abort     = w_wr_ctrl && i_mmio_wr_data[CTRL_ABORT_BIT] && w_busy;

  // CPU always wins port B; an abort in flight also kills the beat.
  assign w_beat = !i_rst && w_busy && !i_fifo_empty && !i_cpu_mem_req && !w_abort;

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    len_d     = len_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q    & ~(w_wr_status & i_mmio_wr_data[STAT_DONE_BIT]);
    aborted_d = aborted_q & ~(w_wr_status & i_mmio_wr_data[STAT_ABORTED_BIT]);

    if (w_wr_ctrl) begin
      irq_en_d = i_mmio_wr_data[CTRL_IRQ_EN_BIT];
    end

    if (state_q == DMA_IDLE) begin
      if (w_wr_dst) begin
        dst_d = {i_mmio_wr_data[31:2], 2'b00};
      end
      if (w_wr_len) begin
        len_d = i_mmio_wr_data[15:0];
      end
      if (w_start) begin
        if (len_q != 16'd0) begin
          state_d = DMA_XFER;
        end else begin
          done_d = 1'b1;
        end
      end
    end else begin
      if (w_abort) begin
        state_d   = DMA_IDLE;
        aborted_d = 1'b1;
      end else if (w_beat) begin
        // Address wraps inside the RAM window; bits above it are held.
        dst_d = (dst_q & ~ADDR_MASK) | ((dst_q + 32'd4) & ADDR_MASK);
        len_d = len_q - 16'd1;
        if (len_q == 16'd1) begin
          state_d = DMA_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    irq_d = irq_en_q && (done_q || aborted_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= DMA_IDLE;
      dst_q     <= '0;
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (i_mmio_rd_addr == MMIO_BASE + DMA_OFF_DST) begin
      w_rd_data = dst_q;
    end else if (i_mmio_rd_addr == MMIO_BASE + DMA_OFF_LEN) begin
      w_rd_data = {16'd0, len_q};
    end else if (i_mmio_rd_addr == MMIO_BASE + DMA_OFF_CTRL) begin
      w_rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
    end else if (i_mmio_rd_addr == MMIO_BASE + DMA_OFF_STATUS) begin
      w_rd_data[STAT_BUSY_BIT]    = w_busy;
      w_rd_data[STAT_DONE_BIT]    = done_q;
      w_rd_data[STAT_ABORTED_BIT] = aborted_q;
    end
  end

  assign o_mmio_rd_data    = w_rd_data;
  assign o_dma_mem_sel     = w_beat;
  assign o_dma_mem_we      = w_beat ? 4'hF : 4'h0;
  assign o_dma_mem_addr    = dst_q;
  assign o_dma_mem_wr_data = i_fifo_rd_data;
  assign o_fifo_rd_en      = w_beat;
  assign o_irq             = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_dma_ctrl.sv
// ============================================================================
// Module : tb_fifo_dma_ctrl
// Brief  : Self-checking bench: register table, directed transfer scenarios
//          and randomized transfers against a transaction-level scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_dma_ctrl;
  import dma_pkg::*;

  localparam int unsigned MEM   = 2**16;
  localparam logic [31:0] MEMW  = 32'(MEM);
  localparam logic [31:0] BASE  = 32'h4000_0030;
  localparam logic [31:0] A_DST = BASE + DMA_OFF_DST;
  localparam logic [31:0] A_LEN = BASE + DMA_OFF_LEN;
  localparam logic [31:0] A_CTL = BASE + DMA_OFF_CTRL;
  localparam logic [31:0] A_STA = BASE + DMA_OFF_STATUS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic [31:0] rd_data;
  logic        cpu_req = 1'b0;
  logic        sel;
  logic [31:0] maddr, mdata;
  logic [3:0]  mwe;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        irq;

  fifo_dma_ctrl #(.MEM_SIZE_BYTES(MEM), .MMIO_BASE(BASE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mmio_wr_en(wr_en), .i_mmio_wr_addr(wr_addr), .i_mmio_wr_data(wr_data),
    .i_mmio_rd_addr(rd_addr), .o_mmio_rd_data(rd_data),
    .i_cpu_mem_req(cpu_req), .o_dma_mem_sel(sel), .o_dma_mem_addr(maddr),
    .o_dma_mem_wr_data(mdata), .o_dma_mem_we(mwe),
    .i_fifo_rd_data(fifo_data), .i_fifo_empty(fifo_empty), .o_fifo_rd_en(fifo_rd_en),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Transaction-level model: start address, beats done, words left.
  logic [31:0] fifo_q[$];
  logic [31:0] m_start;
  int          m_k, m_left, n_supply;
  bit          m_busy;

  typedef struct {
    bit          wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] s, input int k);
    return (s & ~(MEMW - 32'd1)) | ((s + 32'(4 * k)) % MEMW);
  endfunction

  task automatic start_xfer(input logic [31:0] dst, input int len, input bit ien);
    mmio_wr(A_DST, dst);
    mmio_wr(A_LEN, 32'(len));
    mmio_wr(A_CTL, {29'd0, 1'b0, ien, 1'b1});
    m_start = dst & ~32'd3;
    m_k     = 0;
    m_left  = len;
    m_busy  = (len != 0);
  endtask

  // One clock with optional MMIO store; checks the port-B/FIFO handshake.
  task automatic dma_cycle(input bit req, input bit stall, input bit wr,
                           input logic [31:0] wa, input logic [31:0] wd, input string tag);
    bit exp_beat, abort_now;
    if (n_supply > 0 && $urandom_range(1) == 1) begin
      fifo_q.push_back($urandom);
      n_supply--;
    end
    cpu_req    = req;
    fifo_empty = stall || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    wr_en = wr; wr_addr = wa; wr_data = wd;
    #1;
    abort_now = wr && (wa == A_CTL) && wd[CTRL_ABORT_BIT] && m_busy;
    exp_beat  = m_busy && !fifo_empty && !req && !abort_now;
    chk({tag, " sel"}, 32'(sel), 32'(exp_beat));
    chk({tag, " pop"}, 32'(fifo_rd_en), 32'(exp_beat));
    chk({tag, " we"}, {28'd0, mwe}, exp_beat ? 32'hF : 32'h0);
    if (exp_beat) begin
      chk({tag, " addr"}, maddr, exp_addr(m_start, m_k));
      chk({tag, " data"}, mdata, fifo_q[0]);
      m_k++;
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
    if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (abort_now) m_busy = 0;
    tick();
    wr_en = 1'b0;
    cpu_req = 1'b0;
  endtask

  task automatic run_xfer(input int budget, input int req_pct, input int stall_pct,
                          input string tag, output int cycles);
    cycles = 0;
    while (m_busy && cycles < budget) begin
      dma_cycle($urandom_range(99) < req_pct, $urandom_range(99) < stall_pct,
                1'b0, 32'd0, 32'd0, tag);
      cycles++;
    end
    chk({tag, " finished in budget"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] v;

    tbl[0]  = '{0, 32'h0, 32'h0, A_DST, 32'h0};
    tbl[1]  = '{0, 32'h0, 32'h0, A_LEN, 32'h0};
    tbl[2]  = '{0, 32'h0, 32'h0, A_CTL, 32'h0};
    tbl[3]  = '{0, 32'h0, 32'h0, A_STA, 32'h0};
    tbl[4]  = '{1, A_DST, 32'h1234_5677, A_DST, 32'h1234_5674};
    tbl[5]  = '{1, A_LEN, 32'hABCD_0005, A_LEN, 32'h0000_0005};
    tbl[6]  = '{1, A_LEN, 32'h0000_0000, A_LEN, 32'h0};
    tbl[7]  = '{1, A_CTL, 32'h0000_0006, A_CTL, 32'h2};
    tbl[8]  = '{0, 32'h0, 32'h0, A_STA, 32'h0};
    tbl[9]  = '{1, A_CTL, 32'h0000_0003, A_STA, 32'h2};
    tbl[10] = '{0, 32'h0, 32'h0, BASE + 32'h10, 32'h0};
    tbl[11] = '{1, A_STA, 32'h0000_0002, A_STA, 32'h0};
    tbl[12] = '{1, A_CTL, 32'h0000_0000, A_CTL, 32'h0};

    m_busy = 0; n_supply = 0; m_k = 0; m_left = 0; m_start = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset irq", 32'(irq), 32'd0);
    chk("reset sel", 32'(sel), 32'd0);

    // Register map, including LEN=0 start and W1C
    for (int i = 0; i < 13; i++) begin
      wr_en = tbl[i].wr; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      tick();
      wr_en = 1'b0;
      rd_chk($sformatf("table row %0d", i), tbl[i].ra, tbl[i].exp);
    end

    // Basic transfer with interrupt
    mmio_wr(A_DST, 32'h0);
    fifo_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    start_xfer(32'h100, 4, 1'b1);
    run_xfer(20, 0, 0, "basic", cyc);
    chk("basic cycles", 32'(cyc), 32'd4);
    chk("basic irq before", 32'(irq), 32'd0);
    rd_chk("basic status", A_STA, 32'h2);
    rd_chk("basic len", A_LEN, 32'h0);
    rd_chk("basic dst", A_DST, 32'h110);
    tick();
    chk("basic irq after", 32'(irq), 32'd1);

    // CPU contention on beat cycles 2 and 3
    mmio_wr(A_STA, 32'h6);
    fifo_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    start_xfer(32'h200, 4, 1'b0);
    cyc = 0;
    while (m_busy && cyc < 20) begin
      dma_cycle(cyc == 1 || cyc == 2, 1'b0, 1'b0, 32'd0, 32'd0, "contend");
      cyc++;
    end
    chk("contend cycles", 32'(cyc), 32'd6);

    // Wrap at the top of RAM
    fifo_q = '{32'h5555, 32'h6666};
    start_xfer(MEMW - 32'd4, 2, 1'b0);
    run_xfer(20, 0, 0, "wrap", cyc);
    rd_chk("wrap dst", A_DST, 32'h4);

    // FIFO runs dry mid-transfer; DST/LEN stores while busy are ignored
    mmio_wr(A_STA, 32'h6);
    fifo_q = '{32'h77};
    start_xfer(32'h300, 3, 1'b0);
    dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "dry first");
    for (int i = 0; i < 10; i++) begin
      dma_cycle(1'b0, 1'b0, (i == 3) || (i == 6), (i == 3) ? A_DST : A_LEN, 32'h0, "dry wait");
    end
    rd_chk("dry busy", A_STA, 32'h1);
    rd_chk("dry len held", A_LEN, 32'h2);
    fifo_q = '{32'h88, 32'h99};
    run_xfer(20, 0, 0, "dry resume", cyc);
    chk("dry resume cycles", 32'(cyc), 32'd2);
    rd_chk("dry dst", A_DST, 32'h30C);

    // Abort after 2 of 8 beats; the abort cycle has data ready
    mmio_wr(A_STA, 32'h6);
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hC0DE_0000 + 32'(i));
    start_xfer(32'h400, 8, 1'b1);
    dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "abort b1");
    dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "abort b2");
    dma_cycle(1'b0, 1'b0, 1'b1, A_CTL, 32'h6, "abort cyc");
    rd_chk("abort len", A_LEN, 32'h6);
    rd_chk("abort status", A_STA, 32'h4);
    rd_chk("abort dst", A_DST, 32'h408);
    for (int i = 0; i < 3; i++) dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "post abort");
    chk("abort fifo left", 32'(fifo_q.size()), 32'd6);
    chk("abort irq", 32'(irq), 32'd1);

    // DONE W1C in the same cycle as the final beat: set wins
    mmio_wr(A_STA, 32'h6);
    mmio_wr(A_CTL, 32'h0);
    mmio_wr(A_LEN, 32'h0);
    mmio_wr(A_CTL, 32'h1);
    rd_chk("zero len done", A_STA, 32'h2);
    fifo_q = '{32'hAA, 32'hBB};
    start_xfer(32'h500, 2, 1'b0);
    dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "race b1");
    dma_cycle(1'b0, 1'b0, 1'b1, A_STA, 32'h2, "race b2");
    rd_chk("race done", A_STA, 32'h2);

    // Reset mid-transfer
    mmio_wr(A_CTL, 32'h2);
    tick();
    chk("pre-reset irq", 32'(irq), 32'd1);
    fifo_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    start_xfer(32'h600, 5, 1'b1);
    dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "rst b1");
    rst = 1'b1; cpu_req = 1'b0; fifo_empty = 1'b0; fifo_data = fifo_q[0];
    #1;
    chk("rst cyc sel", 32'(sel), 32'd0);
    chk("rst cyc pop", 32'(fifo_rd_en), 32'd0);
    chk("rst cyc we", {28'd0, mwe}, 32'd0);
    tick();
    rst = 1'b0;
    m_busy = 0;
    rd_chk("rst dst", A_DST, 32'h0);
    rd_chk("rst len", A_LEN, 32'h0);
    rd_chk("rst ctrl", A_CTL, 32'h0);
    rd_chk("rst status", A_STA, 32'h0);
    chk("rst irq", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) dma_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "post rst");

    // Randomized transfers with CPU contention and FIFO stalls
    for (int t = 0; t < 25; t++) begin
      int len, pre;
      bit ien;
      logic [31:0] dst;
      mmio_wr(A_STA, 32'h6);
      fifo_q.delete();
      len = $urandom_range(12, 1);
      ien = 1'($urandom_range(1));
      dst = $urandom;
      if ($urandom_range(3) == 0) dst = (dst & ~(MEMW - 32'd1)) | (MEMW - 32'(4 * $urandom_range(3, 1)));
      pre = $urandom_range(len, 0);
      for (int i = 0; i < pre; i++) fifo_q.push_back($urandom);
      n_supply = len - pre;
      start_xfer(dst, len, ien);
      run_xfer(400, 30, 20, $sformatf("rand%0d", t), cyc);
      n_supply = 0;
      rd_chk($sformatf("rand%0d status", t), A_STA, 32'h2);
      rd_chk($sformatf("rand%0d len", t), A_LEN, 32'h0);
      rd_chk($sformatf("rand%0d dst", t), A_DST, exp_addr(dst & ~32'd3, len));
      tick();
      chk($sformatf("rand%0d irq", t), 32'(irq), 32'(ien));
    end

    rd(A_STA, v);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
